memory_map_ctrl: RTL and testbench

Parametrised, registered successor to the combinational memory-map master. It decodes core load/store requests against `NUM_SLAVES` configurable address windows and drives one-hot read/write selects with a word-offset address. It waits on a per-slave ready handshake, with a timeout, and returns registered read data together with `ready`/`err` to the core. It sits between the RISC-V core's data port and the RAM/UART/peripheral slaves.

---
 rtl/memory_map_ctrl_if.sv | 32 +++
 rtl/memory_map_ctrl.sv | 165 ++++++++++++++++
 tb/tb_memory_map_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_map_ctrl_if.sv
// Bus bundle between the memory-map controller, the core data port and the slaves.
// The master modport is the controller; the slave modport is the core/slave side.
interface memory_map_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 3
);
    logic                             req;
    logic                             we;
    logic                             re;
    logic [ADDR_WIDTH-1:0]            address;
    logic [DATA_WIDTH-1:0]            wd;
    logic [DATA_WIDTH-1:0]            rd;
    logic                             ready;
    logic                             err;
    logic [ADDR_WIDTH-1:0]            map_Address;
    logic [DATA_WIDTH-1:0]            map_Data;
    logic [NUM_SLAVES-1:0]            HSel;
    logic [NUM_SLAVES-1:0]            WSel;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] HRData;
    logic [NUM_SLAVES-1:0]            HReady;

    modport master (
        input  req, we, re, address, wd, HRData, HReady,
        output rd, ready, err, map_Address, map_Data, HSel, WSel
    );

    modport slave (
        output req, we, re, address, wd, HRData, HReady,
        input  rd, ready, err, map_Address, map_Data, HSel, WSel
    );
endinterface

// File: rtl/memory_map_ctrl.sv
// Registered memory-map master: window decode, one-hot slave select, ready/timeout handshake.
// Optional MEMORY_MAP_STACK_EN remaps the stack window into STACK_SLAVE with a fixed offset.
module memory_map_ctrl #(
    parameter int                               DATA_WIDTH   = 32,
    parameter int                               ADDR_WIDTH   = 32,
    parameter int                               NUM_SLAVES   = 3,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE   = {32'h1004_0000, 32'h1001_0000, 32'h1001_0020},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_LIMIT  = {32'h7FFF_EFFC, 32'h1003_FFFF, 32'h1001_0040},
    parameter int                               TIMEOUT      = 15,
    parameter logic [ADDR_WIDTH-1:0]            STACK_BASE   = 32'h7FFF_E000,
    parameter int unsigned                      STACK_SLAVE  = 1,
    parameter logic [ADDR_WIDTH-1:0]            STACK_OFFSET = 32'hD4
) (
    input logic               clk,
    input logic               rst,
    memory_map_ctrl_if.master bus
);
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = 8;
    localparam logic [ADDR_WIDTH-1:0] STACK_LIMIT = SLAVE_LIMIT[STACK_SLAVE*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef MEMORY_MAP_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [SEL_W-1:0]      r_sel;
    logic                  r_we;
    logic [NUM_SLAVES-1:0] r_hsel;
    logic [NUM_SLAVES-1:0] r_wsel;
    logic [ADDR_WIDTH-1:0] r_map_address;
    logic [DATA_WIDTH-1:0] r_map_data;
    logic [DATA_WIDTH-1:0] r_rd;
    logic                  r_ready;
    logic                  r_err;

    logic [NUM_SLAVES-1:0] w_hit;
    logic [ADDR_WIDTH-1:0] w_off [NUM_SLAVES];
    logic                  w_dec_hit;
    logic [SEL_W-1:0]      w_dec_sel;
    logic [ADDR_WIDTH-1:0] w_dec_off;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic                  w_in_stack;
    logic [ADDR_WIDTH-1:0] w_stack_off;
    logic                  w_sel_ready;
    logic [DATA_WIDTH-1:0] w_sel_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_window
            localparam logic [ADDR_WIDTH-1:0] BASE  = SLAVE_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH];
            localparam logic [ADDR_WIDTH-1:0] LIMIT = SLAVE_LIMIT[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_hit[gi] = (bus.address >= BASE) && (bus.address <= LIMIT);
            assign w_off[gi] = bus.address - BASE;
        end
    endgenerate

    assign w_in_stack  = (bus.address >= STACK_BASE) && (bus.address <= STACK_LIMIT);
    assign w_stack_off = bus.address - STACK_BASE + STACK_OFFSET;

    // Scan from the top so the lowest-index matching window is the one left standing.
    always_comb begin
        w_dec_hit = |w_hit;
        w_dec_sel = '0;
        w_dec_off = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_dec_sel = SEL_W'(i);
                w_dec_off = w_off[i];
            end
        end
        if (STACK_EN && w_in_stack) begin
            w_dec_hit = 1'b1;
            w_dec_sel = SEL_W'(STACK_SLAVE);
            w_dec_off = w_stack_off;
        end
    end

    assign w_onehot    = NUM_SLAVES'(1) << w_dec_sel;
    assign w_sel_ready = bus.HReady[r_sel];
    assign w_sel_rdata = bus.HRData[r_sel*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_sel         <= '0;
            r_we          <= 1'b0;
            r_hsel        <= '0;
            r_wsel        <= '0;
            r_map_address <= '0;
            r_map_data    <= '0;
            r_rd          <= '0;
            r_ready       <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    if (bus.req && (bus.we || bus.re)) begin
                        r_we       <= bus.we;
                        r_map_data <= bus.wd;
                        if (w_dec_hit) begin
                            r_state       <= ACCESS;
                            r_sel         <= w_dec_sel;
                            r_cnt         <= '0;
                            r_hsel        <= w_onehot;
                            r_wsel        <= bus.we ? w_onehot : '0;
                            r_map_address <= w_dec_off >> 2;
                        end else begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_rd    <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // A completion in the same cycle as the timeout still counts as success.
                    if (w_sel_ready) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                        r_rd    <= r_we ? '0 : w_sel_rdata;
                        r_hsel  <= '0;
                        r_wsel  <= '0;
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                        r_err   <= 1'b1;
                        r_rd    <= '0;
                        r_hsel  <= '0;
                        r_wsel  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rd          = r_rd;
    assign bus.ready       = r_ready;
    assign bus.err         = r_err;
    assign bus.map_Address = r_map_address;
    assign bus.map_Data    = r_map_data;
    assign bus.HSel        = r_hsel;
    assign bus.WSel        = r_wsel;
endmodule

// File: tb/tb_memory_map_ctrl.sv
// Self-checking bench for memory_map_ctrl: directed corner cases plus random traffic,
// checked against a window-table reference model.
module tb_memory_map_ctrl;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 3;
    localparam int TO = 15;
    localparam logic [NS*AW-1:0] BASES  = {32'h1004_0000, 32'h1001_0000, 32'h1001_0020};
    localparam logic [NS*AW-1:0] LIMITS = {32'h7FFF_EFFC, 32'h1003_FFFF, 32'h1001_0040};
    localparam logic [AW-1:0]    STK_BASE  = 32'h7FFF_E000;
    localparam logic [AW-1:0]    STK_OFF   = 32'hD4;
    localparam int               STK_SLAVE = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   txn_n  = 0;

    memory_map_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS)) bus ();

    memory_map_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS),
        .SLAVE_BASE(BASES), .SLAVE_LIMIT(LIMITS), .TIMEOUT(TO),
        .STACK_BASE(STK_BASE), .STACK_SLAVE(STK_SLAVE), .STACK_OFFSET(STK_OFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: stack window first (when enabled), then the first window in index order.
    function automatic void model_decode(input logic [AW-1:0] a, output bit hit, output int sel,
                                         output logic [AW-1:0] word);
        logic [AW-1:0] b;
        logic [AW-1:0] l;
        hit  = 1'b0;
        sel  = 0;
        word = '0;
`ifdef MEMORY_MAP_STACK_EN
        l = LIMITS[STK_SLAVE*AW +: AW];
        if (a >= STK_BASE && a <= l) begin
            hit  = 1'b1;
            sel  = STK_SLAVE;
            word = (a - STK_BASE + STK_OFF) >> 2;
            return;
        end
`endif
        for (int i = 0; i < NS; i++) begin
            b = BASES[i*AW +: AW];
            l = LIMITS[i*AW +: AW];
            if (a >= b && a <= l) begin
                hit  = 1'b1;
                sel  = i;
                word = (a - b) >> 2;
                return;
            end
        end
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        int s;
        s = $urandom_range(0, NS - 1);
        case ($urandom_range(0, 5))
            0: a = 32'h1001_0020 + 32'($urandom_range(0, 8) * 4);
            1: a = 32'h1001_0000 + 32'($urandom_range(0, 16'hFFFF) * 4);
            2: a = 32'h1004_0000 + ($urandom & 32'h0FFF_FFFC);
            3: a = $urandom;
            4: a = ($urandom_range(0, 1) == 1) ? LIMITS[s*AW +: AW] + 32'($urandom_range(0, 1))
                                               : BASES[s*AW +: AW] - 32'($urandom_range(0, 1));
            default: a = 32'($urandom_range(0, 32'h0FFF_FFFF));
        endcase
        return a;
    endfunction

    // Starts in an IDLE cycle (#1 after an edge) and returns in the following IDLE cycle.
    task automatic run_txn(input logic [AW-1:0] a, input bit w, input bit r, input logic [DW-1:0] d,
                           input logic [DW-1:0] sd, input int waits);
        bit            hit;
        int            sel;
        logic [AW-1:0] word;
        logic [NS-1:0] oh;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
        int            lat;
        model_decode(a, hit, sel, word);
        oh = hit ? (NS'(1) << sel) : '0;
        bus.req = 1'b1; bus.we = w; bus.re = r; bus.address = a; bus.wd = d;
        bus.HReady = '0;
        @(posedge clk); #1;
        bus.req = 1'b0;
        txn_n++;
        if (!hit) begin
            check("unmapped_ready", 64'(bus.ready), 64'd1);
            check("unmapped_err",   64'(bus.err),   64'd1);
            check("unmapped_rd",    64'(bus.rd),    64'd0);
            check("unmapped_hsel",  64'(bus.HSel),  64'd0);
            check("unmapped_wsel",  64'(bus.WSel),  64'd0);
            exp_err = 1'b1;
        end else begin
            check("hsel",        64'(bus.HSel),        64'(oh));
            check("wsel",        64'(bus.WSel),        64'(w ? oh : '0));
            check("map_address", 64'(bus.map_Address), 64'(word));
            check("map_data",    64'(bus.map_Data),    64'(d));
            check("ready_early", 64'(bus.ready),       64'd0);
            exp_err = (waits > TO);
            lat     = exp_err ? TO + 1 : waits + 1;
            exp_rd  = '0;
            for (int k = 1; k <= lat; k++) begin
                if (k > 1) begin
                    check("hold_hsel",        64'(bus.HSel),        64'(oh));
                    check("hold_map_address", 64'(bus.map_Address), 64'(word));
                    check("hold_ready",       64'(bus.ready),       64'd0);
                end
                bus.HRData = {$urandom, $urandom, $urandom};
                bus.HRData[sel*DW +: DW] = sd;
                bus.HReady = NS'($urandom) & ~oh;
                if (k > waits) begin
                    bus.HReady = bus.HReady | oh;
                    exp_rd = w ? '0 : sd;
                end
                bus.req = 1'($urandom); bus.we = 1'($urandom); bus.re = 1'($urandom);
                bus.address = $urandom; bus.wd = $urandom;
                @(posedge clk); #1;
            end
            check("resp_ready", 64'(bus.ready), 64'd1);
            check("resp_err",   64'(bus.err),   64'(exp_err));
            check("resp_rd",    64'(bus.rd),    64'(exp_rd));
            check("resp_hsel",  64'(bus.HSel),  64'd0);
            check("resp_wsel",  64'(bus.WSel),  64'd0);
        end
        bus.HReady = NS'($urandom);
        bus.req = 1'($urandom); bus.we = 1'($urandom); bus.re = 1'($urandom); bus.address = $urandom;
        @(posedge clk); #1;
        bus.req = 1'b0;
        bus.HReady = '0;
        check("ready_pulse", 64'(bus.ready), 64'd0);
        check("err_pulse",   64'(bus.err),   64'd0);
        $display("txn %0d addr=%h we=%0b re=%0b hit=%0b slave=%0d waits=%0d exp_err=%0b",
                 txn_n, a, w, r, hit, sel, waits, exp_err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},    64'(bus.rd),          64'd0);
        check({tag, "_ready"}, 64'(bus.ready),       64'd0);
        check({tag, "_err"},   64'(bus.err),         64'd0);
        check({tag, "_maddr"}, 64'(bus.map_Address), 64'd0);
        check({tag, "_mdata"}, 64'(bus.map_Data),    64'd0);
        check({tag, "_hsel"},  64'(bus.HSel),        64'd0);
        check({tag, "_wsel"},  64'(bus.WSel),        64'd0);
    endtask

    initial begin
        bit w;
        bit r;
        int op;
        bus.req = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.address = '0; bus.wd = '0;
        bus.HRData = '0; bus.HReady = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        run_txn(32'h1001_0004, 1'b0, 1'b1, 32'h0, 32'hCAFE_0001, 0);
        run_txn(32'h1001_0024, 1'b1, 1'b0, 32'hA5A5_A5A5, $urandom, 2);
        run_txn(32'h0000_1000, 1'b0, 1'b1, 32'h0, $urandom, 0);
        run_txn(32'h1001_0004, 1'b0, 1'b1, 32'h0, $urandom, 16);
        run_txn(32'h1001_0004, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 15);
        run_txn(32'h7FFF_E000, 1'b0, 1'b1, 32'h0, $urandom, 1);
        run_txn(32'h1001_0008, 1'b1, 1'b1, 32'h0BAD_F00D, $urandom, 0);
        run_txn(32'h7FFF_EFFC, 1'b0, 1'b1, 32'h0, $urandom, 0);
        run_txn(32'h7FFF_F000, 1'b0, 1'b1, 32'h0, $urandom, 0);
        run_txn(32'h1001_0040, 1'b0, 1'b1, 32'h0, $urandom, 0);
        run_txn(32'h1001_0044, 1'b1, 1'b0, $urandom, $urandom, 3);
        run_txn(32'h1003_FFFF, 1'b0, 1'b1, 32'h0, $urandom, 0);
        run_txn(32'h1004_0000, 1'b0, 1'b1, 32'h0, $urandom, 0);
        run_txn(32'h1000_FFFF, 1'b1, 1'b0, $urandom, $urandom, 0);

        // Request without we/re must not start a transfer.
        bus.req = 1'b1; bus.we = 1'b0; bus.re = 1'b0; bus.address = 32'h1001_0004;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("noop_hsel",  64'(bus.HSel),  64'd0);
        check("noop_ready", 64'(bus.ready), 64'd0);
        @(posedge clk); #1;
        check("noop_ready2", 64'(bus.ready), 64'd0);

        // Reset while slave 1 is stalled in ACCESS.
        bus.req = 1'b1; bus.we = 1'b1; bus.re = 1'b0; bus.address = 32'h1001_0004; bus.wd = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("stall_hsel", 64'(bus.HSel), 64'h2);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midrst");
        run_txn(32'h1001_0010, 1'b0, 1'b1, 32'h0, 32'h0F0F_0F0F, 1);

        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 2);
            w  = (op != 0);
            r  = (op != 1);
            run_txn(rand_addr(), w, r, $urandom, $urandom,
                    ($urandom_range(0, 7) == 0) ? 17 : $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
